// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA plot arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE = round robin, LOCKED = owner only)
//   - default coordinate/colour widths for the supported adapter resolutions
package vga_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // 640x480
    localparam int XW_640 = 10;
    localparam int YW_640 = 9;
    // 320x240
    localparam int XW_320 = 9;
    localparam int YW_320 = 8;
    // 160x120
    localparam int XW_160 = 8;
    localparam int YW_160 = 7;

    // Adapter COLOR_DEPTH options
    localparam int CW_HI  = 9;
    localparam int CW_MID = 6;
    localparam int CW_LO  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches req starting at ptr+1 (modulo NUM_REQ) and returns the first
// asserted requester.
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  PW       index of the last served requester
//   gnt      out NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx  out PW       index of the granted requester (0 when none)
//   gnt_vld  out 1        any request present
module rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_idx,
    output logic               gnt_vld
);
    import vga_arb_pkg::*;

    logic [2*NUM_REQ-1:0] req2;
    logic [NUM_REQ-1:0]   rot;
    int                   pos;
    int                   sum;

    always_comb begin
        // Rotate so that bit 0 of rot is requester ptr+1; doubling the
        // vector makes the wrap-around free.
        req2    = {req, req} >> (32'(ptr) + 32'd1);
        rot     = req2[NUM_REQ-1:0];
        pos     = 0;
        // Descending scan leaves pos at the lowest set bit.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[PW'(k)]) begin
                pos = k;
            end
        end
        gnt_vld = |rot;
        sum     = (32'(ptr) + 1 + pos) % NUM_REQ;
        gnt_idx = gnt_vld ? PW'(sum) : '0;
        gnt     = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port between NUM_REQ drawing engines.
// Round-robin grant per pixel; a requester may lock ownership for a burst of
// at most MAX_BURST pixels. Pixel outputs are registered (1-cycle latency).
// Optional feature: define VGA_ARB_CLIP_EN to drop (consume but not plot)
// pixels with x >= X_MAX or y >= Y_MAX.
// Ports:
//   CLOCK_50   in  1           system clock
//   reset      in  1           synchronous active-high reset
//   req        in  NUM_REQ     per-requester valid
//   req_lock   in  NUM_REQ     keep ownership after the current pixel
//   req_x      in  NUM_REQ*XW  packed x, requester i at [i*XW +: XW]
//   req_y      in  NUM_REQ*YW  packed y
//   req_color  in  NUM_REQ*CW  packed colour
//   ack        out NUM_REQ     combinational one-hot grant
//   owner      out PW          last granted requester
//   VGA_X      out XW          registered pixel x
//   VGA_Y      out YW          registered pixel y
//   VGA_COLOR  out CW          registered pixel colour
//   plot       out 1           registered write strobe
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int CW        = 9,
    parameter int MAX_BURST = 64,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*XW-1:0] req_x,
    input  logic [NUM_REQ*YW-1:0] req_y,
    input  logic [NUM_REQ*CW-1:0] req_color,
    output logic [NUM_REQ-1:0]    ack,
    output logic [PW-1:0]         owner,
    output logic [XW-1:0]         VGA_X,
    output logic [YW-1:0]         VGA_Y,
    output logic [CW-1:0]         VGA_COLOR,
    output logic                  plot
);

    localparam int CNTW = $clog2(MAX_BURST + 1);

`ifdef VGA_ARB_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CW-1:0]     color_q, color_d;
    logic              plot_q, plot_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_vld;

    logic [NUM_REQ-1:0] own_mask;
    logic [PW-1:0]      sel;
    logic               xfer;
    logic               lock_sel;
    logic [CNTW-1:0]    cnt_inc;
    logic [XW-1:0]      x_sel;
    logic [YW-1:0]      y_sel;
    logic [CW-1:0]      c_sel;
    logic               in_range;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        plot_d   = 1'b0;
        ack      = '0;
        sel      = owner_q;
        own_mask = NUM_REQ'(1) << owner_q;
        cnt_inc  = cnt_q + CNTW'(1);

        // Grant selection; reset forces a silent cycle.
        if (!reset) begin
            if (state_q == IDLE) begin
                ack = pick_gnt;
                sel = pick_idx;
            end else begin
                ack = own_mask & req;
                sel = owner_q;
            end
        end
        xfer     = |ack;
        lock_sel = |(req_lock & ((state_q == IDLE) ? ack : own_mask));

        x_sel    = XW'(req_x     >> (32'(sel) * XW));
        y_sel    = YW'(req_y     >> (32'(sel) * YW));
        c_sel    = CW'(req_color >> (32'(sel) * CW));
        // Out-of-range pixels are consumed but never reach the adapter.
        in_range = !CLIP_ON || ((32'(x_sel) < X_MAX) && (32'(y_sel) < Y_MAX));

        if (xfer && in_range) begin
            x_d     = x_sel;
            y_d     = y_sel;
            color_d = c_sel;
            plot_d  = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    ptr_d   = sel;
                    owner_d = sel;
                    if (lock_sel && (MAX_BURST > 1)) begin
                        state_d = LOCKED;
                        cnt_d   = CNTW'(1);
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                end
                // ptr already equals owner, so release hands priority onward.
                if (!lock_sel || (xfer && (cnt_inc == CNTW'(MAX_BURST)))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
        end
    end

    assign owner     = owner_q;
    assign VGA_X     = x_q;
    assign VGA_Y     = y_q;
    assign VGA_COLOR = color_q;
    assign plot      = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
module tb_vga_plot_arbiter;

    localparam int NR = 3;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 9;
    localparam int MB = 4;
    localparam int PW = 2;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_lock;
    logic [NR*XW-1:0] req_x;
    logic [NR*YW-1:0] req_y;
    logic [NR*CW-1:0] req_color;
    logic [NR-1:0]    ack;
    logic [PW-1:0]    owner;
    logic [XW-1:0]    VGA_X;
    logic [YW-1:0]    VGA_Y;
    logic [CW-1:0]    VGA_COLOR;
    logic             plot;

    logic [XW-1:0] rx [NR];
    logic [YW-1:0] ry [NR];
    logic [CW-1:0] rc [NR];

    int n_tot;
    int n_bad;

    // Reference model state
    int            m_ptr;
    bit            m_locked;
    int            m_owner;
    int            m_cnt;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic [CW-1:0] m_c;
    logic          m_plot;

    logic [NR-1:0] obs_ack;
    logic [NR-1:0] last_ack;

    vga_plot_arbiter #(
        .NUM_REQ   (NR),
        .XW        (XW),
        .YW        (YW),
        .CW        (CW),
        .MAX_BURST (MB),
        .X_MAX     (640),
        .Y_MAX     (480)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .req       (req),
        .req_lock  (req_lock),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .ack       (ack),
        .owner     (owner),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        for (int i = 0; i < NR; i++) begin
            req_x[i*XW +: XW]     = rx[i];
            req_y[i*YW +: YW]     = ry[i];
            req_color[i*CW +: CW] = rc[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit clipped(input int i);
`ifdef VGA_ARB_CLIP_EN
        return (int'(rx[i]) >= 640) || (int'(ry[i]) >= 480);
`else
        return 1'b0;
`endif
    endfunction

    // Who should be granted right now, from the rules in plain terms.
    function automatic logic [NR-1:0] model_ack();
        logic [NR-1:0] r;
        r = '0;
        if (reset) return r;
        if (m_locked) begin
            if (req[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (req[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic [NR-1:0] ea);
        int w;
        w = -1;
        for (int i = 0; i < NR; i++) if (ea[i]) w = i;
        if (reset) begin
            m_ptr = NR - 1; m_locked = 0; m_owner = 0; m_cnt = 0;
            m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
            return;
        end
        m_plot = 1'b0;
        if (w >= 0 && !clipped(w)) begin
            m_x = rx[w]; m_y = ry[w]; m_c = rc[w]; m_plot = 1'b1;
        end
        if (!m_locked) begin
            if (w >= 0) begin
                m_ptr = w;
                m_owner = w;
                if (req_lock[w] && MB > 1) begin
                    m_locked = 1;
                    m_cnt = 1;
                end
            end
        end else begin
            if (w >= 0) m_cnt++;
            if (!req_lock[m_owner] || (w >= 0 && m_cnt == MB)) begin
                m_locked = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] ea;
        @(negedge clk);
        ea = model_ack();
        obs_ack = ack;
        chk("ack", 32'(ack), 32'(ea));
        @(posedge clk);
        #1;
        model_step(ea);
        chk("plot", 32'(plot), 32'(m_plot));
        chk("vga_x", 32'(VGA_X), 32'(m_x));
        chk("vga_y", 32'(VGA_Y), 32'(m_y));
        chk("vga_color", 32'(VGA_COLOR), 32'(m_c));
        chk("owner", 32'(owner), 32'(m_owner));
        last_ack = ea;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req_lock = '0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic new_pixel(input int i);
        rx[i] = ($urandom % 8 == 0) ? XW'($urandom_range(640, 1023)) : XW'($urandom_range(0, 639));
        ry[i] = ($urandom % 8 == 0) ? YW'($urandom_range(480, 511)) : YW'($urandom_range(0, 479));
        rc[i] = CW'($urandom);
    endtask

    initial begin
        logic [NR-1:0] seq4 [7];
        n_tot = 0;
        n_bad = 0;
        reset = 1'b1;
        req = '0;
        req_lock = '0;
        for (int i = 0; i < NR; i++) begin
            rx[i] = '0; ry[i] = '0; rc[i] = '0;
        end
        m_ptr = NR - 1; m_locked = 0; m_owner = 0; m_cnt = 0;
        m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
        last_ack = '0;

        cycle();
        cycle();
        chk("rst_plot", 32'(plot), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_x", 32'(VGA_X), 0);

        // Single request
        reset = 1'b0;
        req = 3'b001;
        rx[0] = 10'd5; ry[0] = 9'd7; rc[0] = 9'h1FF;
        cycle();
        chk("t1_ack", 32'(obs_ack), 32'h1);
        chk("t1_plot", 32'(plot), 1);
        chk("t1_x", 32'(VGA_X), 5);
        chk("t1_y", 32'(VGA_Y), 7);
        chk("t1_color", 32'(VGA_COLOR), 32'h1FF);
        req = '0;
        cycle();
        chk("t1_hold_plot", 32'(plot), 0);
        chk("t1_hold_x", 32'(VGA_X), 5);

        // Three requesters, no lock
        do_reset();
        for (int i = 0; i < NR; i++) new_pixel(i);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t2_gnt", 32'(obs_ack), 32'(1 << (k % 3)));
            chk("t2_plot", 32'(plot), 1);
        end

        // Requester 1 locks for 4 pixels
        do_reset();
        req = 3'b010;
        req_lock = 3'b010;
        cycle();
        chk("t3_gnt0", 32'(obs_ack), 32'h2);
        req = 3'b111;
        cycle();
        chk("t3_gnt1", 32'(obs_ack), 32'h2);
        cycle();
        chk("t3_gnt2", 32'(obs_ack), 32'h2);
        req_lock = 3'b000;
        cycle();
        chk("t3_gnt3", 32'(obs_ack), 32'h2);
        cycle();
        chk("t3_next", 32'(obs_ack), 32'h4);

        // Burst limit with requester 0 holding lock
        do_reset();
        seq4 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111;
        req_lock = 3'b001;
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk("t4_gnt", 32'(obs_ack), 32'(seq4[k]));
        end

        // Reset during a locked burst
        do_reset();
        req = 3'b001;
        req_lock = 3'b001;
        cycle();
        reset = 1'b1;
        cycle();
        chk("t5_ack", 32'(obs_ack), 0);
        chk("t5_plot", 32'(plot), 0);
        reset = 1'b0;
        req = 3'b111;
        req_lock = '0;
        cycle();
        chk("t5_prio", 32'(obs_ack), 32'h1);

`ifdef VGA_ARB_CLIP_EN
        do_reset();
        req = 3'b001;
        rx[0] = 10'd12; ry[0] = 9'd3;
        cycle();
        rx[0] = 10'd700; ry[0] = 9'd10;
        cycle();
        chk("t6_clip_ack", 32'(obs_ack), 32'h1);
        chk("t6_clip_plot", 32'(plot), 0);
        chk("t6_clip_x", 32'(VGA_X), 12);
        rx[0] = 10'd639; ry[0] = 9'd479;
        cycle();
        chk("t6_edge_plot", 32'(plot), 1);
        chk("t6_edge_x", 32'(VGA_X), 639);
`endif

        // Randomized traffic against the reference model
        do_reset();
        req = '0;
        req_lock = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (last_ack[i]) begin
                    req[i] = ($urandom % 4 != 0);
                    new_pixel(i);
                end else if (!req[i] && ($urandom % 3 == 0)) begin
                    req[i] = 1'b1;
                    new_pixel(i);
                end
                req_lock[i] = ($urandom % 3 != 0);
            end
            reset = ($urandom % 250 == 0);
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
